// File: rtl/adder_result_fifo.sv
// Result queue behind the adder: first-word fall-through from registered storage, head visible the cycle after a push.
// No backpressure toward the adder; results arriving while full with no pop are dropped and counted (sticky overflow).
module adder_result_fifo #(
  parameter int NOF_BITS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NOF_BITS-1:0]       in_data,
  input  logic                      in_done,
  output logic [NOF_BITS-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  input  logic                      clr_ovf,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [NOF_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push  = in_done && (!w_full || w_pop);
  assign w_drop  = in_done && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= in_data;
  end

  // A drop in the clearing cycle wins, so it is never silently lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (clr_ovf) begin
      r_overflow <= w_drop;
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;
    end
  end

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo (DEPTH=4, NOF_BITS=8): vector table plus overflow-saturation and reset sequences.
module tb_adder_result_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       clr_ovf;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  adder_result_fifo #(.NOF_BITS(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_done(in_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .clr_ovf(clr_ovf),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       done;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    int         cnt;
    logic       vld;
    logic [7:0] dq;
    logic       fl;
    logic       ovf;
    int         drop;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic d, input logic [7:0] di,
                              input logic rd, input logic c, input int cn, input logic v,
                              input logic [7:0] dq, input logic f, input logic o, input int dr);
    vec_t x;
    x.rst = r; x.done = d; x.din = di; x.rdy = rd; x.clr = c;
    x.cnt = cn; x.vld = v; x.dq = dq; x.fl = f; x.ovf = o; x.drop = dr;
    return x;
  endfunction

  task automatic cmp(input string tag, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, name, act, act, exp, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic drive(input vec_t v);
    rst = v.rst; in_done = v.done; in_data = v.din; out_ready = v.rdy; clr_ovf = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input vec_t v, input string tag);
    cmp(tag, "count",     int'(count),     v.cnt);
    cmp(tag, "out_valid", int'(out_valid), int'(v.vld));
    cmp(tag, "empty",     int'(empty),     int'(!v.vld));
    cmp(tag, "out_data",  int'(out_data),  int'(v.dq));
    cmp(tag, "full",      int'(full),      int'(v.fl));
    cmp(tag, "overflow",  int'(overflow),  int'(v.ovf));
    cmp(tag, "drop_cnt",  int'(drop_cnt),  v.drop);
  endtask

  vec_t tbl [24];

  initial begin
    rst = 1'b1; in_done = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;

    //             rst done din   rdy clr  cnt vld dout  full ovf drop
    tbl[0]  = mk(1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h05, 0, 0,   1, 1, 8'h05, 0, 0, 0);
    tbl[2]  = mk(0, 1, 8'h0A, 0, 0,   2, 1, 8'h05, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'hFF, 0, 0,   3, 1, 8'h05, 0, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 0,   2, 1, 8'h0A, 0, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0,   1, 1, 8'hFF, 0, 0, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 0);
    tbl[12] = mk(0, 1, 8'h01, 0, 0,   1, 1, 8'h01, 0, 0, 0);
    tbl[13] = mk(0, 1, 8'h02, 0, 0,   2, 1, 8'h01, 0, 0, 0);
    tbl[14] = mk(0, 1, 8'h03, 0, 0,   3, 1, 8'h01, 0, 0, 0);
    tbl[15] = mk(0, 1, 8'h04, 0, 0,   4, 1, 8'h01, 1, 0, 0);
    tbl[16] = mk(0, 1, 8'h05, 0, 0,   4, 1, 8'h01, 1, 1, 1);
    tbl[17] = mk(0, 1, 8'h06, 0, 0,   4, 1, 8'h01, 1, 1, 2);
    tbl[18] = mk(0, 1, 8'h77, 1, 0,   4, 1, 8'h02, 1, 1, 2);
    tbl[19] = mk(0, 0, 8'h00, 1, 0,   3, 1, 8'h03, 0, 1, 2);
    tbl[20] = mk(0, 0, 8'h00, 1, 0,   2, 1, 8'h04, 0, 1, 2);
    tbl[21] = mk(0, 0, 8'h00, 1, 0,   1, 1, 8'h77, 0, 1, 2);
    tbl[22] = mk(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 2);
    tbl[23] = mk(0, 0, 8'h00, 0, 1,   0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i]);
      check(tbl[i], $sformatf("vec%0d", i));
    end

    // 300 results into a stalled consumer: 4 stored, 296 dropped, counter saturates.
    for (int i = 0; i < 300; i++)
      drive(mk(0, 1, 8'(i + 1), 0, 0, 0, 0, 8'h00, 0, 0, 0));
    check(mk(0, 0, 8'h00, 0, 0, 4, 1, 8'h01, 1, 1, 255), "sat");
    begin
      vec_t v;
      v = mk(0, 1, 8'h99, 0, 1, 4, 1, 8'h01, 1, 1, 1);
      drive(v); check(v, "clr_with_drop");
      v = mk(0, 0, 8'h00, 0, 1, 4, 1, 8'h01, 1, 0, 0);
      drive(v); check(v, "clr_alone");

      // Reset mid-operation with a push and pop pending.
      v = mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      drive(v); check(v, "rst2");
      v = mk(0, 1, 8'h11, 0, 0, 1, 1, 8'h11, 0, 0, 0); drive(v);
      v = mk(0, 1, 8'h22, 0, 0, 2, 1, 8'h11, 0, 0, 0); drive(v);
      v = mk(0, 1, 8'h33, 0, 0, 3, 1, 8'h11, 0, 0, 0);
      drive(v); check(v, "fill3");
      v = mk(1, 1, 8'h44, 1, 0, 0, 0, 8'h00, 0, 0, 0);
      drive(v); check(v, "rst_midop");
      v = mk(0, 1, 8'h3C, 0, 0, 1, 1, 8'h3C, 0, 0, 0);
      drive(v); check(v, "push_after_rst");
      v = mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);
      drive(v); check(v, "drain_after_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 SHALL have parameter NOF_BITS, default 8, result word width (matches adder output width).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  NOF_BITS  adder result (adder data_out).
REQ-006 SHALL have port in_done  input  1  result-valid strobe (adder done); no backpressure toward adder.
REQ-007 SHALL have port out_data  output  NOF_BITS  head-of-queue result.
REQ-008 SHALL have port out_valid  output  1  head entry present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
REQ-014 SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-015 SHALL have port drop_cnt  output  8  dropped-result count, saturating.

Function
REQ-016 SHALL push in_data when in_done=1 and (full=0 or pop occurs in same cycle).
REQ-017 SHALL pop when out_valid=1 and out_ready=1; pop removes head at clock edge.
REQ-018 SHALL be first-word fall-through from registered storage: out_data = stored head entry, out_valid = !empty; no same-cycle input-to-output bypass.
REQ-019 SHALL, on push into empty queue, assert out_valid on the cycle after the push edge.
REQ-020 SHALL, on simultaneous push and pop, keep count unchanged; when full, push is accepted (no drop).
REQ-021 SHALL, on in_done=1 with full=1 and no pop, discard in_data, set overflow=1, increment drop_cnt.
REQ-022 SHALL saturate drop_cnt at 255; further drops leave it 255, overflow stays 1.
REQ-023 SHALL, on clr_ovf=1 without a drop, set overflow=0 and drop_cnt=0 next cycle.
REQ-024 SHALL, on clr_ovf=1 coincident with a drop, result in overflow=1, drop_cnt=1.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; occupancy tracked by count, not pointer compare.
REQ-026 SHALL follow occupancy states EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); push only: +1; pop only: -1; both or neither: hold.
REQ-027 SHALL ignore out_ready when empty (no underflow, count stays 0).
REQ-028 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-029 SHALL preserve arrival order; values stored unmodified, full NOF_BITS width.
REQ-030 SHALL drive out_data=0 when empty.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set count=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0, both pointers 0.
REQ-032 SHALL give rst priority over in_done, out_ready and clr_ovf; a push or pop coincident with rst is lost.
REQ-033 SHALL, after rst mid-operation with queue non-empty, discard all stored entries; first push after reset appears as head.
REQ-034 SHALL leave storage array contents unreset; only pointers/flags reset.

Verification
REQ-035 SHALL cover: after reset, in_done pulses with 0x05,0x0A,0xFF, out_ready=0 -> count=3, out_data=0x05; then out_ready=1 for 3 cycles -> outputs 0x05,0x0A,0xFF in order, empty=1.
REQ-036 SHALL cover: 6 consecutive pushes 0x01..0x06, out_ready=0, DEPTH=4 -> full=1, overflow=1, drop_cnt=2, queue holds 0x01..0x04.
REQ-037 SHALL cover: queue full, in_done=1 with 0x77 and out_ready=1 same cycle -> no drop, count=4, tail entry 0x77, head advances.
REQ-038 SHALL cover: 300 pushes with out_ready=0 -> drop_cnt=255; clr_ovf=1 with in_done=1 -> overflow=1, drop_cnt=1; clr_ovf=1 alone -> both 0.
REQ-039 SHALL cover: count=3, rst=1 with in_done=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; following push 0x3C -> out_data=0x3C one cycle later.
REQ-040 SHALL cover: empty queue, out_ready=1 held 5 cycles, no in_done -> count=0, out_valid=0 throughout.
